pipe_ctrl_tracker: RTL and testbench
====================================

Name: pipe_ctrl_tracker

Overview:
- Downstream end of the Control → datapath interface for PMIPSL0. Accepts the decoded control bundle and register fields at ID, then carries them through EX, MEM and WB stage registers.
- Detects RAW hazards against in-flight writers and returns an interlock request to Control. This replaces the fixed three-bubble sequencing with stalls only where needed.
- Sits between Control/IF-ID and the EX/MEM/WB datapath muxes.

Parameters:
- REGW, 3, register-number width (8 registers; r0 hardwired zero).
- CNTW, 16, width of retired-instruction counter.
- WB_BYPASS, 1, 1 = register file writes in first half-cycle, so the WB stage never causes a hazard; 0 = WB stage is checked too.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction (Control not issuing a bubble).
- id_regwrite, id_regdst, id_alusrc, id_branch, id_memwrite, id_memread, id_memtoreg  in  1 each  control bits from Control.
- id_aluop  in  2  ALUOp from Control.
- id_rs, id_rt, id_rd  in  REGW each  instruction register fields.
- flush  in  1  branch taken (resolved in MEM); kills EX and MEM contents.
- hazard_stall  out  1  combinational; Control holds PC and IF/ID, and EX receives a bubble.
- ex_alusrc, ex_regdst  out  1 each; ex_aluop  out  2  EX-stage controls.
- mem_branch, mem_memwrite, mem_memread  out  1 each  MEM-stage controls.
- wb_regwrite, wb_memtoreg  out  1 each; wb_dest  out  REGW  WB-stage controls.
- retired  out  CNTW  count of instructions leaving WB with valid=1.

Behaviour:
- State: three stage registers (EX, MEM, WB). Each holds valid, the full control bundle and dest.
- dest = id_regdst ? id_rd : id_rt, computed at ID.
- Every output control is stage_valid AND stage_bit. Invalid stages drive all-zero controls.
- Reset (synchronous): all valid=0, all controls 0, wb_dest=0, retired=0, hazard_stall=0. Reset overrides flush and stall.
- Latency: an instruction accepted at ID in cycle n drives EX outputs in n+1, MEM in n+2, WB in n+3. It is counted in retired at the edge ending n+3.
- Source usage:
  - rs is read whenever id_valid.
  - rt is read when id_alusrc=0 (R-type, beq) or id_memwrite=1 (sw data).
- Hazard: hazard_stall=1 iff id_valid and some stage S in {EX, MEM, plus WB if WB_BYPASS=0} has S.valid, S.regwrite, S.dest≠0, and S.dest equals a used source.
- Stall cycle: EX loads a bubble (valid=0). MEM←EX and WB←MEM still advance. ID inputs are held stable by upstream.
- Normal cycle: EX←ID bundle with valid=id_valid, MEM←EX, WB←MEM.
- flush=1:
  - EX and MEM load bubbles; WB←MEM still advances, since the branch in MEM has no writeback anyway.
  - hazard_stall still evaluates, but EX gets a bubble regardless.
- r0: a writer with dest=0 never causes a hazard.
- retired wraps modulo 2^CNTW.
- Reset mid-operation: all in-flight instructions are discarded, and retired does not count them.

Test Plan:
- Reset then idle: hold reset 2 cycles with id_valid=0 → all outputs 0, retired=0, hazard_stall=0.
- Independent stream: issue addi r1 (rt=1, alusrc=1, regwrite=1) then addi r2 (rs=0) back-to-back → no stall; ex_alusrc=1 in cycles 1 and 2; wb_dest=1 at cycle 3 and 2 at cycle 4; retired=2 after cycle 4.
- RAW interlock: addi r1, then add r3,r1,r2 (rs=1, regdst=1) → hazard_stall=1 for 2 cycles (WB_BYPASS=1). The add reaches EX in cycle 4, and retired increments by 1 for each of the two.
- Store data dependency: lw r4 (dest=4), then sw with rt=4, rs=0, alusrc=1, memwrite=1 → stall, because rt is used when memwrite=1. Repeat with an addi using rt=4 → no stall.
- r0 writer: addi with dest=0, then add reading rs=0 → hazard_stall stays 0.
- Flush: beq in MEM, two valid instructions in EX/ID, assert flush 1 cycle → next cycle mem_memwrite=0 and mem_memread=0, EX invalid; those two are never counted in retired.

Source files
------------

// File: rtl/pipe_ctrl_tracker.sv
// rtl/pipe_ctrl_tracker.sv - EX/MEM/WB control tracker with RAW hazard interlock
//
// Carries the decoded control bundle from ID through the EX, MEM and WB stage
// registers and raises an interlock toward Control when the instruction in ID
// reads a register that an in-flight instruction has yet to write back.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   id_valid                     ID holds a real instruction
//   id_regwrite .. id_memtoreg   single-bit controls from Control
//   id_aluop                     ALUOp from Control
//   id_rs, id_rt, id_rd          instruction register fields
//   flush                        taken branch in MEM; kills EX and MEM
//   hazard_stall                 combinational interlock request to Control
//   ex_alusrc, ex_regdst, ex_aluop            EX-stage controls
//   mem_branch, mem_memwrite, mem_memread     MEM-stage controls
//   wb_regwrite, wb_memtoreg, wb_dest         WB-stage controls
//   retired                      count of valid instructions leaving WB

module pipe_ctrl_tracker #(
    parameter int REGW      = 3,
    parameter int CNTW      = 16,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_valid,
    input  logic            id_regwrite,
    input  logic            id_regdst,
    input  logic            id_alusrc,
    input  logic            id_branch,
    input  logic            id_memwrite,
    input  logic            id_memread,
    input  logic            id_memtoreg,
    input  logic [1:0]      id_aluop,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic [REGW-1:0] id_rd,
    input  logic            flush,
    output logic            hazard_stall,
    output logic            ex_alusrc,
    output logic            ex_regdst,
    output logic [1:0]      ex_aluop,
    output logic            mem_branch,
    output logic            mem_memwrite,
    output logic            mem_memread,
    output logic            wb_regwrite,
    output logic            wb_memtoreg,
    output logic [REGW-1:0] wb_dest,
    output logic [CNTW-1:0] retired
);

    // Each stage keeps only the fields that it or a later stage consumes.
    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            regdst;
        logic            alusrc;
        logic [1:0]      aluop;
        logic            branch;
        logic            memwrite;
        logic            memread;
        logic            memtoreg;
        logic [REGW-1:0] dest;
    } ex_stage_t;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            branch;
        logic            memwrite;
        logic            memread;
        logic            memtoreg;
        logic [REGW-1:0] dest;
    } mem_stage_t;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memtoreg;
        logic [REGW-1:0] dest;
    } wb_stage_t;

    ex_stage_t       ex_q,  ex_d;
    mem_stage_t      mem_q, mem_d;
    wb_stage_t       wb_q,  wb_d;
    logic [CNTW-1:0] retired_q, retired_d;

    // rt is a true source for R-type/beq (alusrc=0) and for store data.
    logic use_rt;
    logic hit_ex, hit_mem, hit_wb, hazard_raw;

    function automatic logic writer_hits(input logic            v,
                                         input logic            rw,
                                         input logic [REGW-1:0] d,
                                         input logic [REGW-1:0] rs,
                                         input logic [REGW-1:0] rt,
                                         input logic            rt_used);
        // r0 is hardwired zero, so a writer targeting it never conflicts.
        return v && rw && (d != '0) && ((d == rs) || (rt_used && (d == rt)));
    endfunction

    assign use_rt  = !id_alusrc || id_memwrite;
    assign hit_ex  = writer_hits(ex_q.valid,  ex_q.regwrite,  ex_q.dest,  id_rs, id_rt, use_rt);
    assign hit_mem = writer_hits(mem_q.valid, mem_q.regwrite, mem_q.dest, id_rs, id_rt, use_rt);
    assign hit_wb  = writer_hits(wb_q.valid,  wb_q.regwrite,  wb_q.dest,  id_rs, id_rt, use_rt);

    // With write-first register file the WB writer is already visible to ID.
    assign hazard_raw   = id_valid && (hit_ex || hit_mem || (!WB_BYPASS && hit_wb));
    assign hazard_stall = hazard_raw && !reset;

    always_comb begin
        ex_d      = '0;
        mem_d     = '0;
        wb_d      = '0;
        retired_d = retired_q + CNTW'(wb_q.valid);

        // A stalled or flushed slot enters EX as an all-zero bubble.
        if (id_valid && !hazard_raw && !flush) begin
            ex_d.valid    = 1'b1;
            ex_d.regwrite = id_regwrite;
            ex_d.regdst   = id_regdst;
            ex_d.alusrc   = id_alusrc;
            ex_d.aluop    = id_aluop;
            ex_d.branch   = id_branch;
            ex_d.memwrite = id_memwrite;
            ex_d.memread  = id_memread;
            ex_d.memtoreg = id_memtoreg;
            ex_d.dest     = id_regdst ? id_rd : id_rt;
        end

        if (!flush) begin
            mem_d.valid    = ex_q.valid;
            mem_d.regwrite = ex_q.regwrite;
            mem_d.branch   = ex_q.branch;
            mem_d.memwrite = ex_q.memwrite;
            mem_d.memread  = ex_q.memread;
            mem_d.memtoreg = ex_q.memtoreg;
            mem_d.dest     = ex_q.dest;
        end

        // The branch sitting in MEM during a flush has no writeback, so WB
        // advances unconditionally.
        wb_d.valid    = mem_q.valid;
        wb_d.regwrite = mem_q.regwrite;
        wb_d.memtoreg = mem_q.memtoreg;
        wb_d.dest     = mem_q.dest;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            retired_q <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            retired_q <= retired_d;
        end
    end

    assign ex_alusrc    = ex_q.valid && ex_q.alusrc;
    assign ex_regdst    = ex_q.valid && ex_q.regdst;
    assign ex_aluop     = ex_q.aluop & {2{ex_q.valid}};
    assign mem_branch   = mem_q.valid && mem_q.branch;
    assign mem_memwrite = mem_q.valid && mem_q.memwrite;
    assign mem_memread  = mem_q.valid && mem_q.memread;
    assign wb_regwrite  = wb_q.valid && wb_q.regwrite;
    assign wb_memtoreg  = wb_q.valid && wb_q.memtoreg;
    assign wb_dest      = wb_q.dest & {REGW{wb_q.valid}};
    assign retired      = retired_q;

endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// tb/tb_pipe_ctrl_tracker.sv - scoreboard bench for pipe_ctrl_tracker

module tb_pipe_ctrl_tracker;

    // {regwrite, regdst, alusrc, branch, memwrite, memread, memtoreg, aluop}
    localparam logic [8:0] C_NOP  = 9'b0_0_0_0_0_0_0_00;
    localparam logic [8:0] C_ADDI = 9'b1_0_1_0_0_0_0_00;
    localparam logic [8:0] C_ADD  = 9'b1_1_0_0_0_0_0_10;
    localparam logic [8:0] C_LW   = 9'b1_0_1_0_0_1_1_00;
    localparam logic [8:0] C_SW   = 9'b0_0_1_0_1_0_0_00;
    localparam logic [8:0] C_BEQ  = 9'b0_0_0_1_0_0_0_01;

    logic        clock;
    logic        reset;
    logic        id_valid;
    logic        id_regwrite, id_regdst, id_alusrc, id_branch;
    logic        id_memwrite, id_memread, id_memtoreg;
    logic [1:0]  id_aluop;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic        flush;
    logic        hazard_stall;
    logic        ex_alusrc, ex_regdst;
    logic [1:0]  ex_aluop;
    logic        mem_branch, mem_memwrite, mem_memread;
    logic        wb_regwrite, wb_memtoreg;
    logic [2:0]  wb_dest;
    logic [15:0] retired;

    pipe_ctrl_tracker #(.REGW(3), .CNTW(16), .WB_BYPASS(1'b1)) dut (
        .clock        (clock),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_regwrite  (id_regwrite),
        .id_regdst    (id_regdst),
        .id_alusrc    (id_alusrc),
        .id_branch    (id_branch),
        .id_memwrite  (id_memwrite),
        .id_memread   (id_memread),
        .id_memtoreg  (id_memtoreg),
        .id_aluop     (id_aluop),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .flush        (flush),
        .hazard_stall (hazard_stall),
        .ex_alusrc    (ex_alusrc),
        .ex_regdst    (ex_regdst),
        .ex_aluop     (ex_aluop),
        .mem_branch   (mem_branch),
        .mem_memwrite (mem_memwrite),
        .mem_memread  (mem_memread),
        .wb_regwrite  (wb_regwrite),
        .wb_memtoreg  (wb_memtoreg),
        .wb_dest      (wb_dest),
        .retired      (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected vector: {hz, ex{alusrc,regdst,aluop}, mem{branch,memwrite,memread},
    //                   wb{regwrite,memtoreg,dest}, retired}
    typedef struct {
        int          tag;
        logic [28:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_no  = 0;

    task automatic cyc(input logic v, input logic [8:0] ctl,
                       input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                       input logic fl,
                       input logic hz, input logic [3:0] ex, input logic [2:0] mem,
                       input logic [4:0] wb, input logic [15:0] ret);
        exp_t e;
        id_valid    = v;
        id_regwrite = ctl[8];
        id_regdst   = ctl[7];
        id_alusrc   = ctl[6];
        id_branch   = ctl[5];
        id_memwrite = ctl[4];
        id_memread  = ctl[3];
        id_memtoreg = ctl[2];
        id_aluop    = ctl[1:0];
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        flush       = fl;
        cyc_no++;
        e.tag = cyc_no;
        e.v   = {hz, ex, mem, wb, ret};
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle(input logic hz, input logic [3:0] ex, input logic [2:0] mem,
                        input logic [4:0] wb, input logic [15:0] ret);
        cyc(1'b0, C_NOP, 3'd0, 3'd0, 3'd0, 1'b0, hz, ex, mem, wb, ret);
    endtask

    // Monitor: outputs are sampled away from the rising edge and checked
    // against the oldest outstanding expectation.
    initial begin
        exp_t        e;
        logic [28:0] act;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {hazard_stall, ex_alusrc, ex_regdst, ex_aluop,
                       mem_branch, mem_memwrite, mem_memread,
                       wb_regwrite, wb_memtoreg, wb_dest, retired};
                n_tests++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL cycle%0d: got hz=%b ex=%b mem=%b wb=%b ret=%0d, want hz=%b ex=%b mem=%b wb=%b ret=%0d",
                             e.tag, act[28], act[27:24], act[23:21], act[20:16], act[15:0],
                             e.v[28], e.v[27:24], e.v[23:21], e.v[20:16], e.v[15:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        id_valid = 1'b0; id_regwrite = 1'b0; id_regdst = 1'b0; id_alusrc = 1'b0;
        id_branch = 1'b0; id_memwrite = 1'b0; id_memread = 1'b0; id_memtoreg = 1'b0;
        id_aluop = 2'b00; id_rs = 3'd0; id_rt = 3'd0; id_rd = 3'd0; flush = 1'b0;
        @(negedge clock);

        // Reset then idle
        idle(1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd0);
        idle(1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd0);
        reset = 1'b0;

        // Independent stream: addi r1, addi r2
        cyc(1'b1, C_ADDI, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd0);
        cyc(1'b1, C_ADDI, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0, 4'b1000, 3'b000, 5'b00_000, 16'd0);
        idle(1'b0, 4'b1000, 3'b000, 5'b00_000, 16'd0);
        idle(1'b0, 4'b0000, 3'b000, 5'b10_001, 16'd0);
        idle(1'b0, 4'b0000, 3'b000, 5'b10_010, 16'd1);
        idle(1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd2);

        // RAW interlock: addi r1; add r3,r1,r2 held for two stall cycles
        cyc(1'b1, C_ADDI, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd2);
        cyc(1'b1, C_ADD,  3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 4'b1000, 3'b000, 5'b00_000, 16'd2);
        cyc(1'b1, C_ADD,  3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 4'b0000, 3'b000, 5'b00_000, 16'd2);
        cyc(1'b1, C_ADD,  3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 4'b0000, 3'b000, 5'b10_001, 16'd2);
        idle(1'b0, 4'b0110, 3'b000, 5'b00_000, 16'd3);
        idle(1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd3);
        idle(1'b0, 4'b0000, 3'b000, 5'b10_011, 16'd3);
        idle(1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd4);

        // Store data dependency: lw r4; sw rt=4 stalls
        cyc(1'b1, C_LW, 3'd0, 3'd4, 3'd0, 1'b0, 1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd4);
        cyc(1'b1, C_SW, 3'd0, 3'd4, 3'd0, 1'b0, 1'b1, 4'b1000, 3'b000, 5'b00_000, 16'd4);
        cyc(1'b1, C_SW, 3'd0, 3'd4, 3'd0, 1'b0, 1'b1, 4'b0000, 3'b001, 5'b00_000, 16'd4);
        cyc(1'b1, C_SW, 3'd0, 3'd4, 3'd0, 1'b0, 1'b0, 4'b0000, 3'b000, 5'b11_100, 16'd4);
        // lw r4; addi with rt=4 (immediate form, rt not read) does not stall
        cyc(1'b1, C_LW,   3'd0, 3'd4, 3'd0, 1'b0, 1'b0, 4'b1000, 3'b000, 5'b00_000, 16'd5);
        cyc(1'b1, C_ADDI, 3'd0, 3'd4, 3'd0, 1'b0, 1'b0, 4'b1000, 3'b010, 5'b00_000, 16'd5);
        idle(1'b0, 4'b1000, 3'b001, 5'b00_100, 16'd5);
        idle(1'b0, 4'b0000, 3'b000, 5'b11_100, 16'd6);
        idle(1'b0, 4'b0000, 3'b000, 5'b10_100, 16'd7);
        idle(1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd8);

        // r0 writer followed by a reader of r0
        cyc(1'b1, C_ADDI, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd8);
        cyc(1'b1, C_ADD,  3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 4'b1000, 3'b000, 5'b00_000, 16'd8);
        idle(1'b0, 4'b0110, 3'b000, 5'b00_000, 16'd8);
        idle(1'b0, 4'b0000, 3'b000, 5'b10_000, 16'd8);
        idle(1'b0, 4'b0000, 3'b000, 5'b10_101, 16'd9);
        idle(1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd10);

        // Flush: beq reaches MEM with sw in EX and lw in ID
        cyc(1'b1, C_BEQ, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd10);
        cyc(1'b1, C_SW,  3'd0, 3'd6, 3'd0, 1'b0, 1'b0, 4'b0001, 3'b000, 5'b00_000, 16'd10);
        cyc(1'b1, C_LW,  3'd0, 3'd5, 3'd0, 1'b1, 1'b0, 4'b1000, 3'b100, 5'b00_000, 16'd10);
        idle(1'b0, 4'b0000, 3'b000, 5'b00_010, 16'd10);
        idle(1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd11);
        idle(1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd11);

        // Reset mid-operation discards in-flight work and clears the count
        cyc(1'b1, C_ADDI, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd11);
        cyc(1'b1, C_ADDI, 3'd0, 3'd2, 3'd0, 1'b0, 1'b0, 4'b1000, 3'b000, 5'b00_000, 16'd11);
        reset = 1'b1;
        cyc(1'b1, C_ADD,  3'd2, 3'd1, 3'd3, 1'b0, 1'b0, 4'b1000, 3'b000, 5'b00_000, 16'd11);
        reset = 1'b0;
        idle(1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd0);
        idle(1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd0);
        idle(1'b0, 4'b0000, 3'b000, 5'b00_000, 16'd0);

        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
